// File: rtl/crate_bus_capture.sv
// Crate bus front end: synchronises the asynchronous crate write cycle, qualifies the strobe,
// checks the module code and queues accepted {module, port, data} records for a valid/ready sink.
module crate_bus_capture #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [2:0]  VALID_CODE    = 3'b101,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] crate_a,
    input  logic [7:0] crate_d,
    input  logic       crate_strobe_n,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_module,
    output logic [1:0] out_port,
    output logic [7:0] out_data,
    output logic       reject_pulse,
    output logic       overflow,
    input  logic       clear_overflow,
    output logic [7:0] drop_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_CNT = CW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [1:0]    strobe_sync_q;
    logic [17:0]   bus_meta_q;
    logic [17:0]   bus_sync_q;
    logic          strobe_low_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [17:0]   cap_q, cap_d;
    logic          capture_s;
    logic          code_ok_s;
    logic          push_req_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          empty_s;
    logic          full_s;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [14:0]   mem_q [FIFO_DEPTH];
    logic [14:0]   head_s;
    logic          reject_q, reject_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;

    // Two-flop synchronisers; the idle strobe level is high so reset cannot fake a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_sync_q <= 2'b11;
            bus_meta_q    <= 18'd0;
            bus_sync_q    <= 18'd0;
        end else begin
            strobe_sync_q <= {strobe_sync_q[0], crate_strobe_n};
            bus_meta_q    <= {crate_a, crate_d};
            bus_sync_q    <= bus_meta_q;
        end
    end

    assign strobe_low_s = ~strobe_sync_q[1];

    // Strobe qualification FSM: settle, sample once, then wait for the strobe to end.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe_low_s) begin
                    state_d = SETTLE;
                    cnt_d   = {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d   = {CW{1'b0}};
                end
            end
            SETTLE: begin
                if (!strobe_low_s) begin
                    state_d = IDLE;
                end else if (cnt_q == SETTLE_CNT) begin
                    cap_d   = bus_sync_q;
                    state_d = CAPTURE;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            CAPTURE: begin
                capture_s = 1'b1;
                state_d   = RELEASE;
            end
            RELEASE: begin
                if (!strobe_low_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, settle counter and captured bus word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            cap_q   <= 18'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    assign code_ok_s  = (cap_q[17:15] == VALID_CODE);
    assign push_req_s = capture_s & code_ok_s;
    assign empty_s    = (wr_q == rd_q);
    assign full_s     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_s      = ~empty_s & out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign drop_s     = push_req_s & full_s & ~pop_s;

    // Pointer, reject pulse and overflow bookkeeping; a drop outranks a same-cycle clear.
    always_comb begin
        wr_d     = push_s ? wr_q + {{AW{1'b0}}, 1'b1} : wr_q;
        rd_d     = pop_s  ? rd_q + {{AW{1'b0}}, 1'b1} : rd_q;
        reject_d = capture_s & ~code_ok_s;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (drop_s) begin
            ovf_d = 1'b1;
            if (clear_overflow) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end else begin
                drop_d = drop_q;
            end
        end else if (clear_overflow) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end else begin
            ovf_d  = ovf_q;
            drop_d = drop_q;
        end
    end

    // FIFO pointers and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q     <= {(AW+1){1'b0}};
            rd_q     <= {(AW+1){1'b0}};
            reject_q <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            reject_q <= reject_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Record storage, {port, module, data}; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 15'd0;
            end
        end else if (push_s) begin
            mem_q[wr_q[AW-1:0]] <= cap_q[14:0];
        end
    end

    assign head_s       = mem_q[rd_q[AW-1:0]];
    assign out_valid    = ~empty_s;
    assign out_port     = head_s[14:13];
    assign out_module   = head_s[12:8];
    assign out_data     = head_s[7:0];
    assign reject_pulse = reject_q;
    assign overflow     = ovf_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_crate_bus_capture.sv
// Bench for crate_bus_capture: directed and randomized crate cycles checked every clock
// against a transaction-level queue model of the record stream.
module tb_crate_bus_capture;
    localparam int SETTLE = 8;
    localparam int DEPTH  = 4;
    localparam int LAT    = SETTLE + 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] crate_a;
    logic [7:0] crate_d;
    logic       crate_strobe_n;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_module;
    logic [1:0] out_port;
    logic [7:0] out_data;
    logic       reject_pulse;
    logic       overflow;
    logic       clear_overflow;
    logic [7:0] drop_count;

    crate_bus_capture #(.SETTLE_CYCLES(SETTLE), .VALID_CODE(3'b101), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .crate_a(crate_a), .crate_d(crate_d),
        .crate_strobe_n(crate_strobe_n), .out_valid(out_valid), .out_ready(out_ready),
        .out_module(out_module), .out_port(out_port), .out_data(out_data),
        .reject_pulse(reject_pulse), .overflow(overflow), .clear_overflow(clear_overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] m;
        logic [1:0] p;
        logic [7:0] d;
    } rec_t;

    rec_t q[$];
    rec_t pend_rec;
    bit   pend_ok;
    bit   ovf_m = 1'b0;
    int   drops_m = 0;
    int   cycle = 0;
    int   push_cycle = -1;
    int   rdy_mode = 0;
    int   clr_mode = 0;
    int   first_val = -1;
    int   rej_seen = 0;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},  {31'd0, out_valid},    32'd0);
        chk({tag, "_module"}, {27'd0, out_module},   32'd0);
        chk({tag, "_port"},   {30'd0, out_port},     32'd0);
        chk({tag, "_data"},   {24'd0, out_data},     32'd0);
        chk({tag, "_reject"}, {31'd0, reject_pulse}, 32'd0);
        chk({tag, "_ovf"},    {31'd0, overflow},     32'd0);
        chk({tag, "_drops"},  {24'd0, drop_count},   32'd0);
    endtask

    // One clock: drive handshake inputs, advance, update the model, compare everything.
    task automatic step();
        int  sz;
        bit  pop_m, push_m, drop_m, rej_m, clr;
        case (rdy_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            2: out_ready = 1'($urandom_range(0, 1));
            3: out_ready = (cycle + 1 == push_cycle);
            default: out_ready = 1'b0;
        endcase
        case (clr_mode)
            1: clear_overflow = 1'b1;
            2: clear_overflow = (cycle + 1 == push_cycle);
            default: clear_overflow = 1'b0;
        endcase
        clr    = clear_overflow;
        sz     = q.size();
        pop_m  = (sz > 0) && out_ready;
        push_m = (cycle + 1 == push_cycle);
        @(posedge clk);
        #1;
        cycle++;
        if (pop_m) void'(q.pop_front());
        rej_m  = push_m && !pend_ok;
        drop_m = push_m && pend_ok && (sz == DEPTH) && !pop_m;
        if (push_m && pend_ok && !drop_m) q.push_back(pend_rec);
        if (drop_m) begin
            ovf_m   = 1'b1;
            drops_m = clr ? 1 : ((drops_m < 255) ? drops_m + 1 : 255);
        end else if (clr) begin
            ovf_m   = 1'b0;
            drops_m = 0;
        end
        if (clr_mode == 1) clr_mode = 0;
        if (out_valid === 1'b1 && first_val < 0) first_val = cycle;
        if (reject_pulse === 1'b1) rej_seen++;
        chk("valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("module", {27'd0, out_module}, {27'd0, q[0].m});
            chk("port",   {30'd0, out_port},   {30'd0, q[0].p});
            chk("data",   {24'd0, out_data},   {24'd0, q[0].d});
        end
        chk("reject",   {31'd0, reject_pulse}, {31'd0, rej_m});
        chk("overflow", {31'd0, overflow},     {31'd0, ovf_m});
        chk("drops",    {24'd0, drop_count},   32'(drops_m));
    endtask

    // A crate write cycle: bus set up with the strobe fall, held len clocks, then released.
    task automatic strobe(input int len, input logic [2:0] code, input logic [1:0] port,
                          input logic [4:0] mod, input logic [7:0] data);
        int gap;
        crate_a        = {code, port, mod};
        crate_d        = data;
        crate_strobe_n = 1'b0;
        if (len >= SETTLE + 1) begin
            push_cycle = cycle + LAT;
            pend_rec   = '{m: mod, p: port, d: data};
            pend_ok    = (code == 3'b101);
        end
        repeat (len) step();
        crate_strobe_n = 1'b1;
        crate_a        = 10'($urandom);
        crate_d        = 8'($urandom);
        gap = (LAT + 1 - len > 3) ? LAT + 1 - len : 3;
        repeat (gap) step();
    endtask

    initial begin
        int          len;
        logic [2:0]  code;
        reset_n        = 1'b0;
        crate_a        = 10'd0;
        crate_d        = 8'd0;
        crate_strobe_n = 1'b1;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        step();

        // Single record and its latency from strobe fall.
        first_val = -1;
        push_cycle = -1;
        len = cycle;
        strobe(20, 3'b101, 2'b10, 5'd1, 8'hA5);
        chk("t1_latency", 32'(first_val - len), 32'(LAT));
        chk("t1_data", {24'd0, out_data}, 32'h0000_00A5);
        rdy_mode = 1;
        repeat (2) step();
        chk("t1_single", {31'd0, out_valid}, 32'd0);

        // Glitch shorter than the settle window, then a normal write.
        rdy_mode = 0;
        strobe(5, 3'b101, 2'b01, 5'd7, 8'h11);
        chk("t2_none", {31'd0, out_valid}, 32'd0);
        strobe(10, 3'b101, 2'b11, 5'd31, 8'h3C);
        chk("t2_after", {24'd0, out_data}, 32'h0000_003C);
        rdy_mode = 1;
        repeat (2) step();

        // Bad module code held long: exactly one reject.
        rej_seen = 0;
        strobe(20, 3'b011, 2'b00, 5'd2, 8'h99);
        chk("t3_rejects", 32'(rej_seen), 32'd1);
        chk("t3_novalid", {31'd0, out_valid}, 32'd0);

        // Six writes into a four-entry FIFO with the sink stalled.
        rdy_mode = 0;
        for (int i = 1; i <= 6; i++) strobe(12, 3'b101, 2'b00, 5'(i), 8'(i));
        chk("t4_ovf", {31'd0, overflow}, 32'd1);
        chk("t4_drops", {24'd0, drop_count}, 32'd2);
        chk("t4_head", {24'd0, out_data}, 32'd1);
        rdy_mode = 1;
        repeat (6) step();
        chk("t4_empty", {31'd0, out_valid}, 32'd0);
        clr_mode = 1;
        step();
        chk("t4_clr_ovf", {31'd0, overflow}, 32'd0);
        chk("t4_clr_drops", {24'd0, drop_count}, 32'd0);

        // Full FIFO, pop coincides with the push of 0x77.
        rdy_mode = 0;
        for (int i = 1; i <= 4; i++) strobe(12, 3'b101, 2'b01, 5'(i), 8'(8'h11 * i));
        rdy_mode = 3;
        strobe(12, 3'b101, 2'b01, 5'd9, 8'h77);
        chk("t5_nodrop", {24'd0, drop_count}, 32'd0);
        chk("t5_head", {24'd0, out_data}, 32'h0000_0022);
        rdy_mode = 1;
        repeat (6) step();

        // Drop, then drop with a coincident clear, then saturation.
        rdy_mode = 0;
        for (int i = 1; i <= 4; i++) strobe(10, 3'b101, 2'b10, 5'(i), 8'(8'h20 + i));
        strobe(10, 3'b101, 2'b10, 5'd5, 8'h25);
        chk("t7_drop1", {24'd0, drop_count}, 32'd1);
        clr_mode = 2;
        strobe(10, 3'b101, 2'b10, 5'd6, 8'h26);
        clr_mode = 0;
        chk("t7_clrdrop", {24'd0, drop_count}, 32'd1);
        chk("t7_clrovf", {31'd0, overflow}, 32'd1);
        repeat (255) strobe(9, 3'b101, 2'b00, 5'd3, 8'h33);
        chk("t7_sat", {24'd0, drop_count}, 32'd255);
        clr_mode = 1;
        step();
        rdy_mode = 1;
        repeat (6) step();

        // Reset during settle with two records queued.
        rdy_mode = 0;
        strobe(10, 3'b101, 2'b01, 5'd10, 8'hB1);
        strobe(10, 3'b101, 2'b01, 5'd11, 8'hB2);
        crate_a        = {3'b101, 2'b11, 5'd12};
        crate_d        = 8'h5A;
        crate_strobe_n = 1'b0;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        q.delete();
        ovf_m      = 1'b0;
        drops_m    = 0;
        push_cycle = -1;
        chk_reset_outputs("t6");
        repeat (2) step();
        reset_n    = 1'b1;
        push_cycle = cycle + LAT;
        pend_rec   = '{m: 5'd12, p: 2'b11, d: 8'h5A};
        pend_ok    = 1'b1;
        repeat (20) step();
        crate_strobe_n = 1'b1;
        repeat (4) step();
        chk("t6_new", {24'd0, out_data}, 32'h0000_005A);
        rdy_mode = 1;
        repeat (2) step();
        chk("t6_one", {31'd0, out_valid}, 32'd0);

        // Randomized cycles with a random sink and occasional clears.
        rdy_mode = 2;
        repeat (40) begin
            len  = $urandom_range(3, 20);
            code = 3'b101;
            if ($urandom_range(0, 3) == 0) begin
                code = 3'($urandom_range(0, 7));
                if (code == 3'b101) code = 3'b000;
            end
            if ($urandom_range(0, 7) == 0) clr_mode = 1;
            strobe(len, code, 2'($urandom), 5'($urandom), 8'($urandom));
        end
        rdy_mode = 1;
        repeat (8) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
